// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply; divide stays iterative.
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                is_div_q;
    logic                neg_lo_q;
    logic                neg_hi_q;
    logic [DATA_W-1:0]   opb_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] acc_d;
    logic                busy_q;
    logic                done_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;

    logic                is_signed;
    logic                rs_neg;
    logic                rt_neg;
    logic [DATA_W-1:0]   rs_abs;
    logic [DATA_W-1:0]   rt_abs;
    logic                div_zero;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_trial;
    logic [2*DATA_W-1:0] prod_raw;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   fix_hi;
    logic [DATA_W-1:0]   fix_lo;
    logic                cnt_last;

    always_comb begin
        is_signed = ~op[0];
        rs_neg    = is_signed & rs_data[DATA_W-1];
        rt_neg    = is_signed & rt_data[DATA_W-1];
        rs_abs    = rs_neg ? (~rs_data + 1'b1) : rs_data;
        rt_abs    = rt_neg ? (~rt_data + 1'b1) : rt_data;
        div_zero  = op[1] & (rt_data == '0);
        cnt_last  = (cnt_q == CNT_W'(DATA_W - 1));
    end

    // acc holds {partial product, remaining multiplier bits} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_shift = acc_q[2*DATA_W-1:DATA_W-1];
        div_trial = div_shift - {1'b0, opb_q};
        if (is_div_q) begin
            if (!div_trial[DATA_W])
                acc_d = {div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
            else
                acc_d = {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
        end else begin
            acc_d = {mul_sum, acc_q[DATA_W-1:1]};
        end
    end

    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        prod_raw = is_div_q ? acc_q
                 : ({{DATA_W{1'b0}}, opb_q} * {{DATA_W{1'b0}}, acc_q[DATA_W-1:0]});
`else
        prod_raw = acc_q;
`endif
        prod_fix = neg_lo_q ? (~prod_raw + 1'b1) : prod_raw;
        if (is_div_q) begin
            fix_lo = neg_lo_q ? (~acc_q[DATA_W-1:0] + 1'b1) : acc_q[DATA_W-1:0];
            fix_hi = neg_hi_q ? (~acc_q[2*DATA_W-1:DATA_W] + 1'b1) : acc_q[2*DATA_W-1:DATA_W];
        end else begin
            fix_lo = prod_fix[DATA_W-1:0];
            fix_hi = prod_fix[2*DATA_W-1:DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        is_div_q <= op[1];
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        if (div_zero) begin
                            // Remainder slot preloaded with raw rs so FIX emits hi=rs, lo=all ones
                            acc_q    <= {rs_data, {DATA_W{1'b1}}};
                            neg_lo_q <= 1'b0;
                            neg_hi_q <= 1'b0;
                            state_q  <= S_FIX;
                        end else if (op[1]) begin
                            opb_q    <= rt_abs;
                            acc_q    <= {{DATA_W{1'b0}}, rs_abs};
                            neg_lo_q <= rs_neg ^ rt_neg;
                            neg_hi_q <= rs_neg;
                            state_q  <= S_CALC;
                        end else begin
                            opb_q    <= rs_abs;
                            acc_q    <= {{DATA_W{1'b0}}, rt_abs};
                            neg_lo_q <= rs_neg ^ rt_neg;
                            neg_hi_q <= 1'b0;
                            state_q  <= FAST_MUL ? S_FIX : S_CALC;
                        end
                    end else begin
                        if (hi_we) hi_q <= wr_data;
                        if (lo_we) lo_q <= wr_data;
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
                    if (cnt_last) state_q <= S_FIX;
                end
                S_FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit (DATA_W=32)
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    muldiv_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Issue one op; cyc is the number of edges after E0 until done is seen.
    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output logic busy0);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        start = 1'b0;
        busy0 = busy;
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic check_result(input string name, input int cyc, input int exp_cyc,
                                input logic busy0, input logic [31:0] exp_hi,
                                input logic [31:0] exp_lo);
        n_checks++;
        if (cyc !== exp_cyc) begin n_fail++; $display("FAIL %s latency got %0d want %0d", name, cyc, exp_cyc); end
        n_checks++;
        if (busy0 !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_start got %b want 1", name, busy0); end
        n_checks++;
        if (hi !== exp_hi) begin n_fail++; $display("FAIL %s hi got %h want %h", name, hi, exp_hi); end
        n_checks++;
        if (lo !== exp_lo) begin n_fail++; $display("FAIL %s lo got %h want %h", name, lo, exp_lo); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_at_done got %b want 0", name, busy); end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL %s done_width got %b want 0", name, done); end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
        hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset busy_done got %b want 00", {busy, done}); end
        n_checks++;
        if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL reset hilo got %h want 0", {hi, lo}); end
    endtask

    task automatic test_multiply;
        int cyc; logic b0;
        run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, b0);
        check_result("multu_max", cyc, MUL_LAT, b0, 32'hFFFF_FFFE, 32'h0000_0001);
        run(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, cyc, b0);
        check_result("mult_neg", cyc, MUL_LAT, b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run(2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFA, cyc, b0);
        check_result("mult_negneg", cyc, MUL_LAT, b0, 32'h0000_0000, 32'h0000_002A);
    endtask

    task automatic test_divide;
        int cyc; logic b0;
        run(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, cyc, b0);
        check_result("div_neg", cyc, DIV_LAT, b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run(2'b11, 32'd100, 32'd7, cyc, b0);
        check_result("divu", cyc, DIV_LAT, b0, 32'd2, 32'd14);
        run(2'b11, 32'hFFFF_FFFF, 32'h8000_0000, cyc, b0);
        check_result("divu_big", cyc, DIV_LAT, b0, 32'h7FFF_FFFF, 32'h0000_0001);
    endtask

    task automatic test_div_edge;
        int cyc; logic b0;
        run(2'b11, 32'h0000_1234, 32'h0, cyc, b0);
        check_result("divu_zero", cyc, 1, b0, 32'h0000_1234, 32'hFFFF_FFFF);
        run(2'b10, 32'hFFFF_FFF0, 32'h0, cyc, b0);
        check_result("div_zero", cyc, 1, b0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc, b0);
        check_result("div_ovf", cyc, DIV_LAT, b0, 32'h0000_0000, 32'h8000_0000);
    endtask

    task automatic test_mt;
        int cyc; logic b0;
        @(negedge clk); lo_we = 1'b1; wr_data = 32'h55;
        @(negedge clk); lo_we = 1'b0; hi_we = 1'b1; wr_data = 32'h77;
        @(negedge clk); hi_we = 1'b0;
        n_checks++;
        if (lo !== 32'h55) begin n_fail++; $display("FAIL mtlo got %h want 00000055", lo); end
        n_checks++;
        if (hi !== 32'h77) begin n_fail++; $display("FAIL mthi got %h want 00000077", hi); end
        // MT in the same cycle as an accepted start is dropped
        start = 1'b1; op = 2'b11; rs_data = 32'd100; rt_data = 32'd7;
        lo_we = 1'b1; hi_we = 1'b1; wr_data = 32'hAAAA;
        @(posedge clk); #1;
        start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
        n_checks++;
        if ({hi, lo} !== {32'h77, 32'h55}) begin n_fail++; $display("FAIL mt_vs_start got %h want %h", {hi, lo}, {32'h77, 32'h55}); end
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        n_checks++;
        if ({cyc, hi, lo} !== {DIV_LAT, 32'd2, 32'd14}) begin
            n_fail++; $display("FAIL mt_start_result got cyc=%0d hi=%h lo=%h want cyc=%0d hi=2 lo=e", cyc, hi, lo, DIV_LAT);
        end
    endtask

    task automatic test_busy_ignore;
        int cyc;
        logic [63:0] prev;
        prev = {hi, lo};
        @(negedge clk);
        start = 1'b1; op = 2'b10; rs_data = 32'hFFFF_FFF9; rt_data = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (cyc == 10) begin
                start = 1'b1; op = 2'b01; rs_data = 32'd5; rt_data = 32'd3;
                hi_we = 1'b1; wr_data = 32'hDEAD;
            end
            @(posedge clk); #1;
            start = 1'b0; hi_we = 1'b0;
            cyc++;
            if (cyc == 11) begin
                n_checks++;
                if ({hi, lo} !== prev) begin n_fail++; $display("FAIL busy_hold got %h want %h", {hi, lo}, prev); end
            end
        end
        n_checks++;
        if ({cyc, hi, lo} !== {DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            n_fail++; $display("FAIL busy_ignore got cyc=%0d hi=%h lo=%h want cyc=%0d hi=ffffffff lo=fffffffd", cyc, hi, lo, DIV_LAT);
        end
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL no_queue busy_done got %b want 00", {busy, done}); end
    endtask

    task automatic test_reset_mid;
        int cyc; logic b0; int dones;
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs_data = 32'hFFFF_FFFF; rt_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, hi, lo} !== 66'h0) begin
            n_fail++; $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
        end
        @(negedge clk); rst = 1'b0;
        dones = 0;
        repeat (40) begin @(posedge clk); #1; if (done === 1'b1) dones++; end
        n_checks++;
        if (dones !== 0) begin n_fail++; $display("FAIL reset_mid_no_done got %0d pulses want 0", dones); end
        run(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, cyc, b0);
        check_result("after_reset", cyc, MUL_LAT, b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    endtask

    initial begin
        test_reset;
        test_multiply;
        test_divide;
        test_div_edge;
        test_mt;
        test_busy_ignore;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
